alien_swarm: RTL and testbench

Formation-level successor to the single-alien mover. It owns a ROWS x COLS grid of aliens sharing one origin, an alive mask, a march direction, an edge-triggered descend, speed-up as aliens die, and landed/cleared detection. It sits between the game-tick generator and the renderer/collision logic. Each alien's position is origin + (col*SPACING_X, row*SPACING_Y), computed by consumers.

---
 rtl/chip_invaders_pkg.sv | 13 +
 rtl/alien_swarm_bounds.sv | 53 +++++
 rtl/alien_swarm.sv | 176 +++++++++++++++++
 tb/tb_alien_swarm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/chip_invaders_pkg.sv
// Shared types for the invaders formation logic: swarm state and march direction encodings.
package chip_invaders_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LANDED  = 2'd1,
    CLEARED = 2'd2
  } swarm_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/alien_swarm_bounds.sv
// Combinational extent of the alive formation: leftmost/rightmost live column,
// lowest live row and population count.
module alien_swarm_bounds #(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 4,
  localparam int unsigned N     = ROWS * COLS,
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     mask,
  output logic [COL_W-1:0] min_col,
  output logic [COL_W-1:0] max_col,
  output logic [ROW_W-1:0] max_row,
  output logic [CNT_W-1:0] pop
);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  // Collapse the grid onto column and row occupancy vectors.
  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        col_any[c] = col_any[c] | mask[r*int'(COLS)+c];
        row_any[r] = row_any[r] | mask[r*int'(COLS)+c];
      end
    end
  end

  // Empty mask yields zeros; callers treat that as "no formation".
  always_comb begin
    min_col = '0;
    max_col = '0;
    max_row = '0;
    pop     = '0;
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (col_any[c]) min_col = COL_W'(c);
    end
    for (int c = 0; c < int'(COLS); c++) begin
      if (col_any[c]) max_col = COL_W'(c);
    end
    for (int r = 0; r < int'(ROWS); r++) begin
      if (row_any[r]) max_row = ROW_W'(r);
    end
    for (int i = 0; i < int'(N); i++) begin
      pop = pop + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/alien_swarm.sv
// Formation controller: shared origin, alive mask, edge-triggered descend,
// population-scaled step period and landed/cleared detection.
module alien_swarm
  import chip_invaders_pkg::*;
#(
  parameter int unsigned COLS        = 8,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned POS_W       = 16,
  parameter int unsigned ORIGIN_X    = 16,
  parameter int unsigned ORIGIN_Y    = 16,
  parameter int unsigned SPACING_X   = 16,
  parameter int unsigned SPACING_Y   = 12,
  parameter int unsigned ALIEN_W     = 12,
  parameter int unsigned ALIEN_H     = 8,
  parameter int unsigned FIELD_MIN_X = 0,
  parameter int unsigned FIELD_MAX_X = 639,
  parameter int unsigned LAND_Y      = 440,
  parameter int unsigned STEP_X      = 2,
  parameter int unsigned STEP_Y      = 8,
  parameter int unsigned MIN_PERIOD  = 1,
  localparam int unsigned N     = ROWS * COLS,
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             restart,
  input  logic             kill_valid,
  input  logic [ROW_W-1:0] kill_row,
  input  logic [COL_W-1:0] kill_col,
  output logic [POS_W-1:0] origin_x,
  output logic [POS_W-1:0] origin_y,
  output logic [N-1:0]     alive_mask,
  output logic [CNT_W-1:0] alive_count,
  output logic             direction,
  output logic             step_pulse,
  output logic             kill_hit,
  output logic             landed,
  output logic             cleared
);

  localparam int unsigned SW    = POS_W + 1;
  localparam int unsigned TC_W  = $clog2(MIN_PERIOD + N + 1);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  swarm_state_t state_q, state_d;

  logic [TC_W-1:0]  tick_cnt, tick_cnt_d;
  logic [POS_W-1:0] ox_d, oy_d;
  logic [N-1:0]     mask_d;
  logic [CNT_W-1:0] count_d;
  logic             dir_d, step_d, hit_d;

  logic [COL_W-1:0] min_col, max_col;
  logic [ROW_W-1:0] max_row;
  logic [CNT_W-1:0] pop;

  alien_swarm_bounds #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_bounds (
    .mask    (alive_mask),
    .min_col (min_col),
    .max_col (max_col),
    .max_row (max_row),
    .pop     (pop)
  );

  // Edge sums carried one bit wider than the origin so they never wrap.
  logic [SW-1:0]    left_edge, right_next, bottom_edge;
  logic             hit_right, hit_left, land_hit, descend;
  logic [TC_W-1:0]  period_last;
  logic             kill_ok;
  logic [IDX_W-1:0] kill_idx;

  always_comb begin
    left_edge   = SW'(origin_x) + SW'(min_col) * SW'(SPACING_X);
    right_next  = SW'(origin_x) + SW'(max_col) * SW'(SPACING_X) + SW'(ALIEN_W - 1 + STEP_X);
    bottom_edge = SW'(origin_y) + SW'(max_row) * SW'(SPACING_Y) + SW'(ALIEN_H - 1);
    hit_right   = right_next > SW'(FIELD_MAX_X);
    hit_left    = left_edge < SW'(FIELD_MIN_X + STEP_X);
    land_hit    = bottom_edge >= SW'(LAND_Y);
    descend     = (direction == DIR_RIGHT) ? hit_right : hit_left;
    period_last = TC_W'(MIN_PERIOD - 1) + TC_W'(alive_count);
    kill_ok     = (32'(kill_row) < ROWS) && (32'(kill_col) < COLS);
    kill_idx    = IDX_W'(32'(kill_row) * COLS + 32'(kill_col));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state and next datapath values; restart overrides everything.
  always_comb begin
    state_d    = state_q;
    ox_d       = origin_x;
    oy_d       = origin_y;
    mask_d     = alive_mask;
    count_d    = alive_count;
    dir_d      = direction;
    tick_cnt_d = tick_cnt;
    step_d     = 1'b0;
    hit_d      = 1'b0;
    if (restart) begin
      state_d    = RUN;
      ox_d       = POS_W'(ORIGIN_X);
      oy_d       = POS_W'(ORIGIN_Y);
      mask_d     = '1;
      count_d    = CNT_W'(N);
      dir_d      = DIR_RIGHT;
      tick_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (pop == '0)    state_d = CLEARED;
          else if (land_hit) state_d = LANDED;
        end
        default: state_d = state_q;
      endcase

      // An empty formation has no bounds, so it never steps.
      if (state_q == RUN && pop != '0 && tick) begin
        if (tick_cnt >= period_last) begin
          tick_cnt_d = '0;
          step_d     = 1'b1;
          if (descend) begin
            oy_d  = origin_y + POS_W'(STEP_Y);
            dir_d = ~direction;
          end else if (direction == DIR_RIGHT) begin
            ox_d = origin_x + POS_W'(STEP_X);
          end else begin
            ox_d = origin_x - POS_W'(STEP_X);
          end
        end else begin
          tick_cnt_d = tick_cnt + TC_W'(1);
        end
      end

      if (kill_valid && kill_ok && alive_mask[kill_idx]) begin
        mask_d[kill_idx] = 1'b0;
        count_d          = alive_count - CNT_W'(1);
        hit_d            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_x    <= POS_W'(ORIGIN_X);
      origin_y    <= POS_W'(ORIGIN_Y);
      alive_mask  <= '1;
      alive_count <= CNT_W'(N);
      direction   <= DIR_RIGHT;
      tick_cnt    <= '0;
      step_pulse  <= 1'b0;
      kill_hit    <= 1'b0;
      landed      <= 1'b0;
      cleared     <= 1'b0;
    end else begin
      origin_x    <= ox_d;
      origin_y    <= oy_d;
      alive_mask  <= mask_d;
      alive_count <= count_d;
      direction   <= dir_d;
      tick_cnt    <= tick_cnt_d;
      step_pulse  <= step_d;
      kill_hit    <= hit_d;
      landed      <= (state_d == LANDED);
      cleared     <= (state_d == CLEARED);
    end
  end

endmodule

// File: tb/tb_alien_swarm.sv
// Randomised bench for alien_swarm against a grid-level behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_alien_swarm;

  localparam int COLS = 5, ROWS = 3, N = COLS * ROWS;
  localparam int OX0 = 100, OY0 = 16, SX = 16, SY = 12, AW = 12, AH = 8;
  localparam int FMIN = 80, FMAX = 207, LANDY = 80, STX = 4, STY = 8, MINP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0, restart = 1'b0, kill_valid = 1'b0;
  logic [1:0] kill_row = '0;
  logic [2:0] kill_col = '0;
  logic [15:0] origin_x, origin_y;
  logic [N-1:0] alive_mask;
  logic [3:0]  alive_count;
  logic        direction, step_pulse, kill_hit, landed, cleared;

  alien_swarm #(
    .COLS(COLS), .ROWS(ROWS), .POS_W(16), .ORIGIN_X(OX0), .ORIGIN_Y(OY0),
    .SPACING_X(SX), .SPACING_Y(SY), .ALIEN_W(AW), .ALIEN_H(AH),
    .FIELD_MIN_X(FMIN), .FIELD_MAX_X(FMAX), .LAND_Y(LANDY),
    .STEP_X(STX), .STEP_Y(STY), .MIN_PERIOD(MINP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .restart(restart),
    .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col),
    .origin_x(origin_x), .origin_y(origin_y), .alive_mask(alive_mask),
    .alive_count(alive_count), .direction(direction), .step_pulse(step_pulse),
    .kill_hit(kill_hit), .landed(landed), .cleared(cleared)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: alive grid, pixel origin, tick tally; phase 0=marching 1=landed 2=cleared.
  bit m_alive [ROWS][COLS];
  int m_ox, m_oy, m_dir, m_ticks, m_phase;
  bit m_step, m_hit;

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) n += m_alive[r][c];
    return n;
  endfunction

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r*COLS+c] = m_alive[r][c];
    return m;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_alive[r][c] = 1'b1;
    m_ox = OX0; m_oy = OY0; m_dir = 1; m_ticks = 0; m_phase = 0;
    m_step = 0; m_hit = 0;
  endtask

  task automatic model_clock(input bit rs, input bit tk, input bit kv, input int kr, input int kc);
    int cnt, left, right, bottom, nphase;
    left = 1 << 30; right = -1; bottom = -1;
    cnt = m_count();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_alive[r][c]) begin
          if (m_ox + c * SX < left) left = m_ox + c * SX;
          if (m_ox + c * SX + AW - 1 > right) right = m_ox + c * SX + AW - 1;
          if (m_oy + r * SY + AH - 1 > bottom) bottom = m_oy + r * SY + AH - 1;
        end
    m_step = 0; m_hit = 0;
    if (rs) begin
      model_reset();
      return;
    end
    nphase = m_phase;
    if (m_phase == 0 && cnt == 0) nphase = 2;
    else if (m_phase == 0 && bottom >= LANDY) nphase = 1;
    if (m_phase == 0 && cnt > 0 && tk) begin
      if (m_ticks + 1 >= MINP + cnt) begin
        m_ticks = 0;
        m_step  = 1;
        if ((m_dir == 1 && right + STX > FMAX) || (m_dir == 0 && left < FMIN + STX)) begin
          m_oy  = (m_oy + STY) & 16'hffff;
          m_dir = 1 - m_dir;
        end else if (m_dir == 1) m_ox = (m_ox + STX) & 16'hffff;
        else m_ox = (m_ox - STX) & 16'hffff;
      end else m_ticks++;
    end
    if (kv && kr < ROWS && kc < COLS && m_alive[kr][kc]) begin
      m_alive[kr][kc] = 1'b0;
      m_hit = 1;
    end
    m_phase = nphase;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_clock(restart, tick, kill_valid, int'(kill_row), int'(kill_col));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("origin_x", origin_x, m_ox);
      check("origin_y", origin_y, m_oy);
      check("alive_mask", alive_mask, m_mask());
      check("alive_count", alive_count, m_count());
      check("direction", direction, m_dir);
      check("step_pulse", step_pulse, m_step);
      check("kill_hit", kill_hit, m_hit);
      check("landed", landed, m_phase == 1);
      check("cleared", cleared, m_phase == 2);
    end
  end

  task automatic drive(input bit tk, input bit kv, input logic [1:0] kr,
                       input logic [2:0] kc, input bit rs);
    tick = tk; kill_valid = kv; kill_row = kr; kill_col = kc; restart = rs;
    @(negedge clk);
    tick = 0; kill_valid = 0; kill_row = '0; kill_col = '0; restart = 0;
  endtask

  int steps_seen;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;

    check("rst_origin_x", origin_x, 100);
    check("rst_origin_y", origin_y, 16);
    check("rst_count", alive_count, 15);
    check("rst_mask", alive_mask, 15'h7fff);
    check("rst_dir", direction, 1);
    check("rst_flags", {step_pulse, kill_hit, landed, cleared}, 0);

    // Full formation: period 16 ticks, edge at 175, descend after 8 steps.
    repeat (15) drive(1, 0, 0, 0, 0);
    check("pre_step_x", origin_x, 100);
    check("pre_step_pulse", step_pulse, 0);
    drive(1, 0, 0, 0, 0);
    check("step1_x", origin_x, 104);
    check("step1_pulse", step_pulse, 1);
    repeat (128) drive(1, 0, 0, 0, 0);
    check("descend_x", origin_x, 132);
    check("descend_y", origin_y, 24);
    check("descend_dir", direction, 0);

    drive(0, 1, 0, 0, 0);
    check("kill1_hit", kill_hit, 1);
    check("kill1_count", alive_count, 14);
    drive(0, 1, 0, 0, 0);
    check("kill2_hit", kill_hit, 0);
    check("kill2_count", alive_count, 14);
    drive(0, 1, 3, 0, 0);
    check("kill_row_oob", kill_hit, 0);
    drive(0, 1, 0, 5, 0);
    check("kill_col_oob", kill_hit, 0);
    check("kill_oob_count", alive_count, 14);

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) drive(0, 1, 2'(r), 3'(c), 0);
    check("all_dead_count", alive_count, 0);
    drive(0, 0, 0, 0, 0);
    check("cleared_set", cleared, 1);
    repeat (40) drive(1, 0, 0, 0, 0);
    check("cleared_frozen_x", origin_x, 132);
    check("cleared_frozen_y", origin_y, 24);
    drive(1, 1, 0, 0, 1);
    check("restart_mask", alive_mask, 15'h7fff);
    check("restart_x", origin_x, 100);
    check("restart_y", origin_y, 16);
    check("restart_cleared", cleared, 0);

    // March until the bottom row reaches the landing line (five descends).
    for (int i = 0; i < 4000 && !landed; i++) drive(1, 0, 0, 0, 0);
    check("landed_reached", landed, 1);
    check("landed_y", origin_y, 56);
    steps_seen = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1, 0, 0, 0, 0);
      steps_seen += step_pulse;
    end
    check("landed_no_steps", steps_seen, 0);

    // Asynchronous reset in the middle of a period.
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 1, 1, 0);
    repeat (40) drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", origin_x, 100);
    check("arst_y", origin_y, 16);
    check("arst_count", alive_count, 15);
    check("arst_mask", alive_mask, 15'h7fff);
    check("arst_pulses", {step_pulse, kill_hit, landed, cleared}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8000; i++) begin
      bit rs;
      rs = ($urandom_range(0, 2999) == 0) || ((landed || cleared) && $urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
            2'($urandom), 3'($urandom), rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
